// File: rtl/vga_pkg.sv
// Shared VGA timing constants and colour helpers for the timing generator
// and the overlay stages downstream of it.
package vga_pkg;

    localparam int PAL = 640;
    localparam int LAF = 480;
    localparam int PLD = 800;
    localparam int LFD = 525;
    localparam int HPW = 96;
    localparam int HFP = 16;
    localparam int VPW = 2;
    localparam int VFP = 10;

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_t;

    function automatic logic [7:0] rgb332(input logic [2:0] red,
                                          input logic [2:0] green,
                                          input logic [1:0] blue);
        return {red, green, blue};
    endfunction

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing box: position, direction and wall-hit detection,
// updated only on the frame tick.
module bounce_axis
    import vga_pkg::*;
#(
    parameter int LIMIT = 640,
    parameter int SIZE  = 32,
    parameter int STEP  = 2,
    parameter int P0    = 100
) (
    input  logic       ck,
    input  logic       rst_n,
    input  logic       i_tick,
    input  logic       i_load,
    input  logic       i_pause,
    input  logic [9:0] i_load_val,
    output logic [9:0] o_pos,
    output logic       o_hit
);

    localparam logic [10:0] MAX_POS = 11'(LIMIT - SIZE);
    localparam logic [10:0] STEP_V  = 11'(STEP);

    logic [9:0]  r_pos;
    dir_t        r_dir;
    logic [9:0]  w_posNext;
    dir_t        w_dirNext;
    logic        w_hit;
    logic [10:0] w_cur;
    logic [10:0] w_up;
    logic [10:0] w_loadVal;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_pos <= 10'(P0);
            r_dir <= DIR_INC;
        end else begin
            r_pos <= w_posNext;
            r_dir <= w_dirNext;
        end
    end

    // 11-bit compares so pos+STEP can never wrap past the wall.
    always_comb begin
        w_posNext = r_pos;
        w_dirNext = r_dir;
        w_hit     = 1'b0;
        w_cur     = {1'b0, r_pos};
        w_up      = w_cur + STEP_V;
        w_loadVal = {1'b0, i_load_val};
        if (i_tick) begin
            if (i_load) begin
                w_posNext = (w_loadVal > MAX_POS) ? MAX_POS[9:0] : i_load_val;
            end else if (!i_pause) begin
                if (r_dir == DIR_INC) begin
                    if (w_up >= MAX_POS) begin
                        w_posNext = MAX_POS[9:0];
                        w_dirNext = DIR_DEC;
                        w_hit     = 1'b1;
                    end else begin
                        w_posNext = w_up[9:0];
                    end
                end else begin
                    if (w_cur <= STEP_V) begin
                        w_posNext = 10'd0;
                        w_dirNext = DIR_INC;
                        w_hit     = 1'b1;
                    end else begin
                        w_posNext = r_pos - STEP_V[9:0];
                    end
                end
            end
        end
    end

    assign o_pos = r_pos;
    assign o_hit = w_hit;

endmodule

// File: rtl/vga_bounce_box.sv
// Pixel overlay that draws a solid box bouncing around the active area on
// top of the upstream background colour.
module vga_bounce_box
    import vga_pkg::*;
#(
    parameter int         BOX_W     = 32,
    parameter int         BOX_H     = 24,
    parameter int         STEP      = 2,
    parameter int         X0        = 100,
    parameter int         Y0        = 50,
    parameter logic [7:0] BOX_COLOR = 8'hFC,
    parameter int         ALIGN_DLY = 2
) (
    input  logic       ck,
    input  logic       rst_n,
    input  logic [9:0] Hcnt,
    input  logic [9:0] Vcnt,
    input  logic [2:0] bg_red,
    input  logic [2:0] bg_green,
    input  logic [1:0] bg_blue,
    input  logic       pause,
    input  logic       load,
    input  logic [9:0] load_x,
    input  logic [9:0] load_y,
    output logic [2:0] outRed,
    output logic [2:0] outGreen,
    output logic [1:0] outBlue,
    output logic [9:0] box_x,
    output logic [9:0] box_y,
    output logic [7:0] bounce_cnt,
    output logic       corner_hit
);

    logic [9:0]           r_vcntQ;
    logic                 w_tick;
    logic [9:0]           w_boxX;
    logic [9:0]           w_boxY;
    logic                 w_hitX;
    logic                 w_hitY;
    logic [7:0]           r_bounceCnt;
    logic                 r_corner;
    logic [10:0]          w_xEnd;
    logic [10:0]          w_yEnd;
    logic                 w_inside;
    logic [ALIGN_DLY-1:0] r_inDly;
    logic [7:0]           w_bgPix;
    logic [7:0]           r_outPix;

    // First ck of the first blanking line is the single per-frame tick.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_vcntQ <= 10'd0;
        end else begin
            r_vcntQ <= Vcnt;
        end
    end

    assign w_tick = (Vcnt == 10'(LAF)) && (r_vcntQ != 10'(LAF));

    bounce_axis #(
        .LIMIT (PAL),
        .SIZE  (BOX_W),
        .STEP  (STEP),
        .P0    (X0)
    ) u_axisX (
        .ck         (ck),
        .rst_n      (rst_n),
        .i_tick     (w_tick),
        .i_load     (load),
        .i_pause    (pause),
        .i_load_val (load_x),
        .o_pos      (w_boxX),
        .o_hit      (w_hitX)
    );

    bounce_axis #(
        .LIMIT (LAF),
        .SIZE  (BOX_H),
        .STEP  (STEP),
        .P0    (Y0)
    ) u_axisY (
        .ck         (ck),
        .rst_n      (rst_n),
        .i_tick     (w_tick),
        .i_load     (load),
        .i_pause    (pause),
        .i_load_val (load_y),
        .o_pos      (w_boxY),
        .o_hit      (w_hitY)
    );

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_bounceCnt <= 8'd0;
            r_corner    <= 1'b0;
        end else begin
            if (w_hitX || w_hitY) begin
                r_bounceCnt <= r_bounceCnt + 8'd1;
            end
            r_corner <= w_hitX && w_hitY;
        end
    end

    assign w_xEnd   = {1'b0, w_boxX} + 11'(BOX_W);
    assign w_yEnd   = {1'b0, w_boxY} + 11'(BOX_H);
    assign w_inside = (Hcnt >= w_boxX) && ({1'b0, Hcnt} < w_xEnd) &&
                      (Vcnt >= w_boxY) && ({1'b0, Vcnt} < w_yEnd) &&
                      (Hcnt < 10'(PAL)) && (Vcnt < 10'(LAF));

    // Upstream colour trails its counters, so the inside flag is delayed to match.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_inDly <= '0;
        end else begin
            r_inDly[0] <= w_inside;
            for (int i = 1; i < ALIGN_DLY; i++) begin
                r_inDly[i] <= r_inDly[i-1];
            end
        end
    end

    assign w_bgPix = rgb332(bg_red, bg_green, bg_blue);

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_outPix <= 8'd0;
        end else begin
            r_outPix <= r_inDly[ALIGN_DLY-1] ? BOX_COLOR : w_bgPix;
        end
    end

    assign outRed     = r_outPix[7:5];
    assign outGreen   = r_outPix[4:2];
    assign outBlue    = r_outPix[1:0];
    assign box_x      = w_boxX;
    assign box_y      = w_boxY;
    assign bounce_cnt = r_bounceCnt;
    assign corner_hit = r_corner;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Self-checking bench for vga_bounce_box: pixel scoreboard plus
// frame-tick driven position, bounce and reset scenarios.
module tb_vga_bounce_box;

    logic       ck = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] Hcnt = 10'd700;
    logic [9:0] Vcnt = 10'd500;
    logic [2:0] bg_red = 3'd0;
    logic [2:0] bg_green = 3'd0;
    logic [1:0] bg_blue = 2'd0;
    logic       pause = 1'b0;
    logic       load = 1'b0;
    logic [9:0] load_x = 10'd0;
    logic [9:0] load_y = 10'd0;
    logic [2:0] outRed;
    logic [2:0] outGreen;
    logic [1:0] outBlue;
    logic [9:0] box_x;
    logic [9:0] box_y;
    logic [7:0] bounce_cnt;
    logic       corner_hit;
    logic [7:0] outPix;

    int passed = 0;
    int total  = 0;

    typedef struct {
        int v;
        int h0;
        int h1;
    } row_t;

    assign outPix = {outRed, outGreen, outBlue};

    vga_bounce_box dut (
        .ck         (ck),
        .rst_n      (rst_n),
        .Hcnt       (Hcnt),
        .Vcnt       (Vcnt),
        .bg_red     (bg_red),
        .bg_green   (bg_green),
        .bg_blue    (bg_blue),
        .pause      (pause),
        .load       (load),
        .load_x     (load_x),
        .load_y     (load_y),
        .outRed     (outRed),
        .outGreen   (outGreen),
        .outBlue    (outBlue),
        .box_x      (box_x),
        .box_y      (box_y),
        .bounce_cnt (bounce_cnt),
        .corner_hit (corner_hit)
    );

    always #5 ck = ~ck;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit in_box(input int h, input int v, input int bx, input int by);
        return (h >= bx) && (h < bx + 32) && (v >= by) && (v < by + 24) &&
               (h < 640) && (v < 480);
    endfunction

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic go_idle();
        Hcnt = 10'd700;
        Vcnt = 10'd500;
        {bg_red, bg_green, bg_blue} = 8'h00;
    endtask

    task automatic do_tick();
        Vcnt = 10'd479;
        step();
        Vcnt = 10'd480;
        step();
    endtask

    task automatic test_reset();
        go_idle();
        rst_n = 1'b0;
        repeat (3) step();
        total++; if (outPix !== 8'h00) $display("[TB] FAIL reset_out: got %h expected 00", outPix); else passed++;
        total++; if (box_x !== 10'd100) $display("[TB] FAIL reset_x: got %0d expected 100", box_x); else passed++;
        total++; if (box_y !== 10'd50) $display("[TB] FAIL reset_y: got %0d expected 50", box_y); else passed++;
        total++; if (bounce_cnt !== 8'd0) $display("[TB] FAIL reset_cnt: got %0d expected 0", bounce_cnt); else passed++;
        total++; if (corner_hit !== 1'b0) $display("[TB] FAIL reset_corner: got %b expected 0", corner_hit); else passed++;
        rst_n = 1'b1;
        repeat (3) step();
        total++; if (box_x !== 10'd100 || box_y !== 10'd50) $display("[TB] FAIL post_reset_pos: got %0d,%0d expected 100,50", box_x, box_y); else passed++;
    endtask

    task automatic test_box_draw(input int bx, input int by);
        row_t       rows[$];
        bit         flagQ[$];
        bit         f;
        logic [7:0] bg;
        logic [7:0] expPix;
        rows.push_back('{by,      bx - 4,  bx + 35});
        rows.push_back('{by - 1,  bx - 1,  bx + 1});
        rows.push_back('{by + 23, bx - 1,  bx + 1});
        rows.push_back('{by + 23, bx + 30, bx + 33});
        rows.push_back('{by + 24, bx,      bx + 1});
        rows.push_back('{by + 10, bx + 28, bx + 40});
        foreach (rows[r]) begin
            for (int h = rows[r].h0; h <= rows[r].h1; h++) begin
                bg = (r == 0) ? 8'h00 : 8'($urandom_range(0, 255));
                Hcnt = 10'(h);
                Vcnt = 10'(rows[r].v);
                {bg_red, bg_green, bg_blue} = bg;
                flagQ.push_back(in_box(h, rows[r].v, bx, by));
                step();
                if (flagQ.size() == 3) begin
                    f = flagQ.pop_front();
                    expPix = f ? 8'hFC : bg;
                    total++;
                    if (outPix !== expPix)
                        $display("[TB] FAIL pixel(box %0d,%0d) v=%0d h=%0d: got %h expected %h",
                                 bx, by, rows[r].v, h, outPix, expPix);
                    else
                        passed++;
                end
            end
        end
        flagQ.delete();
        go_idle();
        repeat (3) step();
    endtask

    task automatic test_first_tick();
        Vcnt = 10'd300;
        repeat (3) step();
        total++; if (box_x !== 10'd100) $display("[TB] FAIL pre_tick_x: got %0d expected 100", box_x); else passed++;
        do_tick();
        total++; if (box_x !== 10'd102) $display("[TB] FAIL tick1_x: got %0d expected 102", box_x); else passed++;
        total++; if (box_y !== 10'd52) $display("[TB] FAIL tick1_y: got %0d expected 52", box_y); else passed++;
        total++; if (bounce_cnt !== 8'd0) $display("[TB] FAIL tick1_cnt: got %0d expected 0", bounce_cnt); else passed++;
        repeat (4) step();
        total++; if (box_x !== 10'd102 || box_y !== 10'd52) $display("[TB] FAIL single_tick: got %0d,%0d expected 102,52", box_x, box_y); else passed++;
    endtask

    task automatic test_right_bounce();
        load = 1'b1; load_x = 10'd606; load_y = 10'd50;
        do_tick();
        load = 1'b0;
        total++; if (box_x !== 10'd606 || box_y !== 10'd50) $display("[TB] FAIL load_pos: got %0d,%0d expected 606,50", box_x, box_y); else passed++;
        total++; if (bounce_cnt !== 8'd0) $display("[TB] FAIL load_cnt: got %0d expected 0", bounce_cnt); else passed++;
        do_tick();
        total++; if (box_x !== 10'd608 || box_y !== 10'd52) $display("[TB] FAIL rbounce_pos: got %0d,%0d expected 608,52", box_x, box_y); else passed++;
        total++; if (bounce_cnt !== 8'd1) $display("[TB] FAIL rbounce_cnt: got %0d expected 1", bounce_cnt); else passed++;
        total++; if (corner_hit !== 1'b0) $display("[TB] FAIL rbounce_corner: got %b expected 0", corner_hit); else passed++;
        test_box_draw(608, 52);
        do_tick();
        total++; if (box_x !== 10'd606 || box_y !== 10'd54) $display("[TB] FAIL after_rbounce: got %0d,%0d expected 606,54", box_x, box_y); else passed++;
    endtask

    task automatic test_clamp_and_bottom();
        load = 1'b1; load_x = 10'd900; load_y = 10'd470;
        do_tick();
        load = 1'b0;
        total++; if (box_x !== 10'd608 || box_y !== 10'd456) $display("[TB] FAIL clamp_pos: got %0d,%0d expected 608,456", box_x, box_y); else passed++;
        total++; if (bounce_cnt !== 8'd1) $display("[TB] FAIL clamp_cnt: got %0d expected 1", bounce_cnt); else passed++;
        do_tick();
        total++; if (box_x !== 10'd606 || box_y !== 10'd456) $display("[TB] FAIL bbounce_pos: got %0d,%0d expected 606,456", box_x, box_y); else passed++;
        total++; if (bounce_cnt !== 8'd2) $display("[TB] FAIL bbounce_cnt: got %0d expected 2", bounce_cnt); else passed++;
        total++; if (corner_hit !== 1'b0) $display("[TB] FAIL bbounce_corner: got %b expected 0", corner_hit); else passed++;
    endtask

    task automatic test_corner();
        load = 1'b1; load_x = 10'd1; load_y = 10'd1;
        do_tick();
        load = 1'b0;
        total++; if (box_x !== 10'd1 || box_y !== 10'd1) $display("[TB] FAIL corner_load: got %0d,%0d expected 1,1", box_x, box_y); else passed++;
        do_tick();
        total++; if (box_x !== 10'd0 || box_y !== 10'd0) $display("[TB] FAIL corner_pos: got %0d,%0d expected 0,0", box_x, box_y); else passed++;
        total++; if (bounce_cnt !== 8'd3) $display("[TB] FAIL corner_cnt: got %0d expected 3", bounce_cnt); else passed++;
        total++; if (corner_hit !== 1'b1) $display("[TB] FAIL corner_pulse: got %b expected 1", corner_hit); else passed++;
        step();
        total++; if (corner_hit !== 1'b0) $display("[TB] FAIL corner_pulse_end: got %b expected 0", corner_hit); else passed++;
        do_tick();
        total++; if (box_x !== 10'd2 || box_y !== 10'd2) $display("[TB] FAIL corner_reverse: got %0d,%0d expected 2,2", box_x, box_y); else passed++;
        total++; if (bounce_cnt !== 8'd3) $display("[TB] FAIL corner_cnt_hold: got %0d expected 3", bounce_cnt); else passed++;
    endtask

    task automatic test_pause();
        pause = 1'b1;
        for (int t = 0; t < 3; t++) begin
            do_tick();
            total++; if (box_x !== 10'd2 || box_y !== 10'd2) $display("[TB] FAIL pause_tick%0d: got %0d,%0d expected 2,2", t, box_x, box_y); else passed++;
        end
        load = 1'b1; load_x = 10'd300; load_y = 10'd200;
        do_tick();
        load = 1'b0;
        pause = 1'b0;
        total++; if (box_x !== 10'd300 || box_y !== 10'd200) $display("[TB] FAIL pause_load: got %0d,%0d expected 300,200", box_x, box_y); else passed++;
        do_tick();
        total++; if (box_x !== 10'd302 || box_y !== 10'd202) $display("[TB] FAIL resume_pos: got %0d,%0d expected 302,202", box_x, box_y); else passed++;
        load = 1'b1; load_x = 10'd10; load_y = 10'd10;
        Vcnt = 10'd100;
        repeat (5) step();
        load = 1'b0;
        total++; if (box_x !== 10'd302 || box_y !== 10'd202) $display("[TB] FAIL load_no_tick: got %0d,%0d expected 302,202", box_x, box_y); else passed++;
        total++; if (bounce_cnt !== 8'd3) $display("[TB] FAIL pause_cnt: got %0d expected 3", bounce_cnt); else passed++;
    endtask

    task automatic test_reset_midline();
        Hcnt = 10'd310; Vcnt = 10'd210;
        {bg_red, bg_green, bg_blue} = 8'h5A;
        repeat (4) step();
        total++; if (outPix !== 8'hFC) $display("[TB] FAIL midline_drawn: got %h expected fc", outPix); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (outPix !== 8'h00) $display("[TB] FAIL async_out: got %h expected 00", outPix); else passed++;
        total++; if (box_x !== 10'd100 || box_y !== 10'd50) $display("[TB] FAIL async_pos: got %0d,%0d expected 100,50", box_x, box_y); else passed++;
        total++; if (bounce_cnt !== 8'd0) $display("[TB] FAIL async_cnt: got %0d expected 0", bounce_cnt); else passed++;
        step();
        rst_n = 1'b1;
        for (int v = 470; v < 480; v++) begin
            Vcnt = 10'(v);
            step();
        end
        total++; if (box_x !== 10'd100 || box_y !== 10'd50) $display("[TB] FAIL no_early_tick: got %0d,%0d expected 100,50", box_x, box_y); else passed++;
        Vcnt = 10'd480;
        step();
        total++; if (box_x !== 10'd102 || box_y !== 10'd52) $display("[TB] FAIL post_reset_tick: got %0d,%0d expected 102,52", box_x, box_y); else passed++;
    endtask

    initial begin
        test_reset();
        test_box_draw(100, 50);
        test_first_tick();
        test_right_bounce();
        test_clamp_and_bottom();
        test_corner();
        test_pause();
        test_reset_midline();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
